ila_readout: RTL and testbench

//  Readout sequencer downstream of the ILA capture core. On start, it walks the

---
 rtl/ila_readout_pkg.sv | 9 +
 rtl/ila_readout_if.sv | 22 ++
 rtl/ila_readout_addr.sv | 31 +++
 rtl/ila_readout.sv | 80 ++++++++
 tb/tb_ila_readout.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ila_readout_pkg.sv
// ila_readout_pkg: shared read latency, FSM encoding and sizing helper for the ILA readout
package ila_readout_pkg;
  localparam int READ_LAT = 2;
  localparam int CNT_W = $clog2(READ_LAT + 1);
  typedef enum logic [2:0] {RD_IDLE, RD_ADDR, RD_WAIT, RD_OUT, RD_DONE} rd_state_t;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/ila_readout_if.sv
// ila_readout_if: control, core read port and output stream of the ILA readout sequencer
interface ila_readout_if import ila_readout_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int SIGNAL_W = 64,
  parameter int BUFFER_W = 10
);
  localparam int WORDS = ceil_div(SIGNAL_W, DATA_W);
  localparam int SEL_W = DATA_W >= SIGNAL_W ? 1 : $clog2(WORDS);
  logic start, abort, busy, done;
  logic [BUFFER_W-1:0] samples, index;
  logic [SEL_W-1:0] value_select;
  logic [DATA_W-1:0] value, m_data;
  logic m_valid, m_ready, m_last;
  modport master(
    input start, abort, samples, value, m_ready,
    output busy, done, index, value_select, m_data, m_valid, m_last
  );
  modport slave(
    output start, abort, samples, value, m_ready,
    input busy, done, index, value_select, m_data, m_valid, m_last
  );
endinterface

// File: rtl/ila_readout_addr.sv
// ila_readout_addr: nested sample-index / slice-select counter, slice is the inner loop
module ila_readout_addr #(
  parameter int BUFFER_W = 10,
  parameter int SEL_W = 1,
  parameter int WORDS = 2
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_i,
  input  logic                clear,
  input  logic                advance,
  input  logic [BUFFER_W-1:0] last_index,
  output logic [BUFFER_W-1:0] index,
  output logic [SEL_W-1:0]    sel,
  output logic                is_last
);
  logic wrap;
  assign wrap = sel == SEL_W'(WORDS - 1);
  assign is_last = wrap && index == last_index;
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      index <= '0;
      sel <= '0;
    end else if (cke_i && clear) begin
      index <= '0;
      sel <= '0;
    end else if (cke_i && advance) begin
      sel <= wrap ? '0 : sel + SEL_W'(1);
      index <= wrap ? index + BUFFER_W'(1) : index;
    end
endmodule

// File: rtl/ila_readout.sv
// ila_readout: walks the ILA capture buffer through the core read port and streams every word
module ila_readout import ila_readout_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int SIGNAL_W = 64,
  parameter int BUFFER_W = 10
) (
  input logic           clk_i,
  input logic           cke_i,
  input logic           arst_i,
  ila_readout_if.master io
);
  localparam int WORDS = ceil_div(SIGNAL_W, DATA_W);
  localparam int SEL_W = DATA_W >= SIGNAL_W ? 1 : $clog2(WORDS);
  rd_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [BUFFER_W-1:0] last_index;
  logic is_last, kill, accept, advance;
  assign kill = io.abort && state != RD_IDLE;
  assign accept = state == RD_IDLE && io.start && !io.abort;
  assign advance = state == RD_OUT && io.m_ready && !io.m_last && !io.abort;
  assign io.busy = state != RD_IDLE;
  ila_readout_addr #(.BUFFER_W(BUFFER_W), .SEL_W(SEL_W), .WORDS(WORDS)) u_addr (
    .clk_i,
    .cke_i,
    .arst_i,
    .clear(kill || accept),
    .advance,
    .last_index,
    .index(io.index),
    .sel(io.value_select),
    .is_last
  );
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      state <= RD_IDLE;
      cnt <= '0;
      last_index <= '0;
      io.m_data <= '0;
      io.m_valid <= 1'b0;
      io.m_last <= 1'b0;
      io.done <= 1'b0;
    end else if (cke_i) begin
      io.done <= 1'b0;
      if (kill) begin
        state <= RD_IDLE;
        io.m_valid <= 1'b0;
        io.m_last <= 1'b0;
      end else
        case (state)
          RD_IDLE: if (accept) begin
            last_index <= io.samples - BUFFER_W'(1);
            state <= io.samples == '0 ? RD_DONE : RD_ADDR;
          end
          RD_ADDR: begin
            cnt <= '0;
            state <= RD_WAIT;
          end
          // value arrives READ_LAT cycles after the address set on entry to ADDR
          RD_WAIT: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(READ_LAT - 1)) begin
              io.m_data <= io.value;
              io.m_valid <= 1'b1;
              io.m_last <= is_last;
              state <= RD_OUT;
            end
          end
          RD_OUT: if (io.m_ready) begin
            io.m_valid <= 1'b0;
            io.m_last <= 1'b0;
            state <= io.m_last ? RD_DONE : RD_ADDR;
          end
          RD_DONE: begin
            io.done <= 1'b1;
            state <= RD_IDLE;
          end
          default: state <= RD_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ila_readout.sv
// tb_ila_readout: randomized scoreboard bench for the ILA readout sequencer
module tb_ila_readout;
  localparam int DW = 32;
  localparam int SW = 64;
  localparam int BW = 4;
  typedef struct packed {
    logic [BW-1:0] idx;
    logic sel;
    logic [DW-1:0] data;
    logic last;
  } beat_t;
  logic clk = 1'b0;
  logic cke;
  logic arst = 1'b1;
  ila_readout_if #(.DATA_W(DW), .SIGNAL_W(SW), .BUFFER_W(BW)) bus();
  ila_readout #(.DATA_W(DW), .SIGNAL_W(SW), .BUFFER_W(BW)) dut (
    .clk_i(clk),
    .cke_i(cke),
    .arst_i(arst),
    .io(bus)
  );
  always #5 clk = ~clk;
  logic [SW-1:0] mem [16];
  logic [DW-1:0] p1;
  beat_t q[$];
  beat_t e_beat, g_beat;
  int compared = 0, mismatched = 0, exp_done = 0, done_seen = 0, hs_count = 0;
  logic rand_ready = 1'b0, rand_cke = 1'b0, ready_zero = 1'b0, hold_low = 1'b0;
  logic pv = 1'b0, pr = 1'b0, pc = 1'b0, pa = 1'b0, pl = 1'b0, pdone = 1'b0;
  logic [DW-1:0] pd = '0;
  // core read path: two-stage registered lookup of the captured buffer
  always @(posedge clk) begin
    p1 <= mem[bus.index][DW*int'(bus.value_select) +: DW];
    bus.value <= p1;
  end
  // cke is never dropped while a start/abort pulse is being presented
  always @(posedge clk) begin
    #2;
    cke = hold_low ? 1'b0 : (rand_cke && !bus.start && !bus.abort) ? ($urandom_range(0, 9) != 0) : 1'b1;
    bus.m_ready = ready_zero ? 1'b0 : rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
  end
  always @(negedge clk) begin
    if (arst) begin
      pv = 1'b0;
      pdone = 1'b0;
    end else begin
      if (pv && (!pr || !pc) && !pa) begin
        compared++;
        if (!bus.m_valid || bus.m_data != pd || bus.m_last != pl) begin
          mismatched++;
          $display("FAIL hold valid=%0b data=%h last=%0b required valid=1 data=%h last=%0b", bus.m_valid, bus.m_data, bus.m_last, pd, pl);
        end
      end
      if (bus.m_valid && bus.m_ready && cke) begin
        hs_count++;
        compared++;
        g_beat = {bus.index, bus.value_select, bus.m_data, bus.m_last};
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL beat unexpected idx=%0d sel=%0d data=%h last=%0b required none", g_beat.idx, g_beat.sel, g_beat.data, g_beat.last);
        end else begin
          e_beat = q.pop_front();
          if (g_beat != e_beat) begin
            mismatched++;
            $display("FAIL beat idx=%0d sel=%0d data=%h last=%0b required idx=%0d sel=%0d data=%h last=%0b", g_beat.idx, g_beat.sel, g_beat.data, g_beat.last, e_beat.idx, e_beat.sel, e_beat.data, e_beat.last);
          end
        end
      end
      if (bus.done && !pdone) done_seen++;
      pv = bus.m_valid;
      pr = bus.m_ready;
      pc = cke;
      pa = bus.abort;
      pd = bus.m_data;
      pl = bus.m_last;
      pdone = bus.done;
    end
  end
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    compared++;
    if (got !== req) begin
      mismatched++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask
  task automatic start_dump(input int n);
    bus.samples = BW'(n);
    bus.start = 1'b1;
    if (!bus.busy) begin
      exp_done++;
      for (int i = 0; i < n; i++)
        for (int s = 0; s < 2; s++)
          q.push_back('{idx: BW'(i), sel: 1'(s), data: mem[i][DW*s +: DW], last: i == n - 1 && s == 1});
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.samples = BW'($urandom);
  endtask
  task automatic abort_dump();
    logic live;
    live = bus.busy;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    if (live) begin
      exp_done--;
      q.delete();
      check("abort_quiet", 64'({bus.busy, bus.m_valid}), 64'(0));
    end
  endtask
  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check("idle_timeout", 64'(bus.busy), 64'(0));
    @(posedge clk); #1;
  endtask
  task automatic wait_valid();
    int t = 0;
    while (!bus.m_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("valid_timeout", 64'(bus.m_valid), 64'(1));
  endtask
  initial begin
    #800000;
    $display("FAIL watchdog expired compared=%0d", compared);
    $fatal(1);
  end
  initial begin
    int n, t, base;
    logic [63:0] snap;
    for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.samples = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", 64'({bus.index, bus.value_select, bus.m_data, bus.m_valid, bus.m_last, bus.busy, bus.done}), 64'(0));
    arst = 1'b0;
    @(posedge clk); #1;
    start_dump(3);
    wait_idle();
    start_dump(0);
    check("zero_c1", 64'({bus.busy, bus.done, bus.m_valid}), 64'(3'b100));
    @(posedge clk); #1;
    check("zero_c2", 64'({bus.busy, bus.done, bus.m_valid}), 64'(3'b010));
    @(posedge clk); #1;
    check("zero_c3", 64'({bus.busy, bus.done, bus.m_valid}), 64'(3'b000));
    bus.samples = 4'd5;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_idle", 64'(bus.busy), 64'(0));
    base = hs_count;
    start_dump(3);
    t = 0;
    while (hs_count < base + 2 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    ready_zero = 1'b1;
    wait_valid();
    abort_dump();
    ready_zero = 1'b0;
    start_dump(2);
    wait_idle();
    start_dump(15);
    wait_idle();
    start_dump(3);
    @(posedge clk); #3;
    arst = 1'b1;
    #1;
    check("reset_mid_wait", 64'({bus.index, bus.value_select, bus.m_data, bus.m_valid, bus.m_last, bus.busy, bus.done}), 64'(0));
    exp_done--;
    q.delete();
    @(posedge clk); #1;
    arst = 1'b0;
    @(posedge clk); #1;
    ready_zero = 1'b1;
    start_dump(3);
    wait_valid();
    hold_low = 1'b1;
    ready_zero = 1'b0;
    snap = 64'({bus.index, bus.value_select, bus.m_data, bus.m_valid, bus.m_last, bus.busy, bus.done});
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("freeze", 64'({bus.index, bus.value_select, bus.m_data, bus.m_valid, bus.m_last, bus.busy, bus.done}), snap);
    end
    hold_low = 1'b0;
    wait_idle();
    rand_ready = 1'b1;
    rand_cke = 1'b1;
    for (int k = 0; k < 24; k++) begin
      n = (k % 6 == 5) ? 15 : int'($urandom_range(0, 6));
      start_dump(n);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 12)) begin
          @(posedge clk); #1;
        end
        start_dump(int'($urandom_range(1, 5)));
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 25)) begin
          @(posedge clk); #1;
        end
        abort_dump();
      end
      wait_idle();
      check("queue_drained", 64'(q.size()), 64'(0));
    end
    rand_ready = 1'b0;
    rand_cke = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("done_count", 64'(done_seen), 64'(exp_done));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
